// File: rtl/gpio_pkg.sv
// Purpose: shared register word indices and limits for the bidirectional GPIO block.
// Latency: n/a (constants only).
// Backpressure: n/a.
package gpio_pkg;

  // Register word indices on addr_i
  localparam logic [2:0] GPIO_OUT  = 3'd0;  // output latch, rw
  localparam logic [2:0] GPIO_DIR  = 3'd1;  // direction, 1=output, rw
  localparam logic [2:0] GPIO_IN   = 3'd2;  // synchronised pin state, ro
  localparam logic [2:0] GPIO_IE   = 3'd3;  // interrupt enable, rw
  localparam logic [2:0] GPIO_EDGE = 3'd4;  // edge select, 1=rising 0=falling, rw
  localparam logic [2:0] GPIO_IP   = 3'd5;  // interrupt pending, write-1-to-clear
  localparam logic [2:0] GPIO_SET  = 3'd6;  // OUT |= data, wo
  localparam logic [2:0] GPIO_CLR  = 3'd7;  // OUT &= ~data, wo

  localparam int GPIO_MAX_WIDTH = 32;

endpackage

// File: rtl/gpio_sync.sv
// Purpose: multi-flop synchroniser for asynchronous pin inputs.
// Latency: SYNC_STAGES clk_i edges from pin to sync_o.
// Backpressure: none; samples every cycle.
//
// Ports:
//   clk_i   system clock
//   rst_i   synchronous active-high reset, clears every stage
//   async_i asynchronous inputs
//   sync_o  last synchroniser stage
module gpio_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        stage_q[s] <= '0;
      end
    end else begin
      stage_q[0] <= async_i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        stage_q[s] <= stage_q[s-1];
      end
    end
  end

  assign sync_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_bidir.sv
// Purpose: bidirectional GPIO with output latch, direction, set/clear aliases and edge interrupts.
// Latency: register writes take effect at the write edge; pin input reaches IN after SYNC_STAGES edges.
// Backpressure: none; the bus completes every access in one cycle.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   sel_i, wen_i, addr_i   peripheral select, write enable, register word index
//   data_i / data_o        write data / combinational read data (0 when not reading)
//   gpio_i                 asynchronous pin inputs
//   gpio_o, gpio_oe_o      pin output values and output enables
//   irq_o                  level interrupt, |(IP & IE)
module gpio_bidir
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sel_i,
  input  logic             wen_i,
  input  logic [2:0]       addr_i,
  input  logic [31:0]      data_i,
  output logic [31:0]      data_o,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe_o,
  output logic             irq_o
);

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] ie_q;
  logic [WIDTH-1:0] edge_q;
  logic [WIDTH-1:0] ip_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] evt;
  logic [WIDTH-1:0] w1c;
  logic [WIDTH-1:0] wdat;
  logic [WIDTH-1:0] rd_val;
  logic             wr_en;

  gpio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .async_i (gpio_i),
    .sync_o  (sync)
  );

  assign wr_en = sel_i & wen_i;
  assign wdat  = data_i[WIDTH-1:0];

  // Bus data above the pin count carries no meaning for this instance.
  if (WIDTH < 32) begin : g_unused_hi
    logic unused_data_hi;
    assign unused_data_hi = ^data_i[31:WIDTH];
  end

  // Per-bit edge of the selected polarity between previous and current synchronised value.
  assign evt = (edge_q & sync & ~prev_q) | (~edge_q & ~sync & prev_q);

  assign w1c = (wr_en && (addr_i == GPIO_IP)) ? wdat : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q  <= '0;
      dir_q  <= '0;
      ie_q   <= '0;
      edge_q <= '0;
      ip_q   <= '0;
      prev_q <= '0;
    end else begin
      if (wr_en) begin
        case (addr_i)
          GPIO_OUT:  out_q  <= wdat;
          GPIO_DIR:  dir_q  <= wdat;
          GPIO_IE:   ie_q   <= wdat;
          GPIO_EDGE: edge_q <= wdat;
          GPIO_SET:  out_q  <= out_q | wdat;
          GPIO_CLR:  out_q  <= out_q & ~wdat;
          default:   ;  // IN is read-only; IP is handled by the pending update below
        endcase
      end
      prev_q <= sync;
      // A new event is ORed in after the clear, so a same-cycle event survives W1C.
      // Masked events are dropped here rather than latched.
      ip_q   <= (ip_q & ~w1c) | (evt & ie_q);
    end
  end

  always_comb begin
    rd_val = '0;
    case (addr_i)
      GPIO_OUT:  rd_val = out_q;
      GPIO_DIR:  rd_val = dir_q;
      GPIO_IN:   rd_val = sync;
      GPIO_IE:   rd_val = ie_q;
      GPIO_EDGE: rd_val = edge_q;
      GPIO_IP:   rd_val = ip_q;
      default:   rd_val = '0;  // SET/CLR are write-only aliases
    endcase
  end

  always_comb begin
    data_o = '0;
    if (sel_i && !wen_i) begin
      data_o[WIDTH-1:0] = rd_val;
    end
  end

  assign gpio_o    = out_q;
  assign gpio_oe_o = dir_q;
  // Clearing IE masks the line but leaves the pending bit for later inspection.
  assign irq_o     = |(ip_q & ie_q);

endmodule

// File: tb/tb_gpio_bidir.sv
module tb_gpio_bidir;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        sel_i;
  logic        wen_i;
  logic [2:0]  addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic [7:0]  gpio_i;
  logic [7:0]  gpio_o;
  logic [7:0]  gpio_oe_o;
  logic        irq_o;

  int tests = 0;
  int fails = 0;

  gpio_bidir #(
    .WIDTH       (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .sel_i     (sel_i),
    .wen_i     (wen_i),
    .addr_i    (addr_i),
    .data_i    (data_i),
    .data_o    (data_o),
    .gpio_i    (gpio_i),
    .gpio_o    (gpio_o),
    .gpio_oe_o (gpio_oe_o),
    .irq_o     (irq_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance past the next rising edge; outputs are sampled 1 ns later.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    sel_i  = 1'b1;
    wen_i  = 1'b1;
    addr_i = a;
    data_i = d;
    tick(1);
    sel_i  = 1'b0;
    wen_i  = 1'b0;
    data_i = '0;
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
    sel_i  = 1'b1;
    wen_i  = 1'b0;
    addr_i = a;
    #1;
    chk(tag, data_o, exp);
    sel_i  = 1'b0;
  endtask

  initial begin
    rst_i  = 1'b1;
    sel_i  = 1'b0;
    wen_i  = 1'b0;
    addr_i = '0;
    data_i = '0;
    gpio_i = 8'hFF;

    // Reset held two cycles with all pins high
    tick(2);
    chk("rst_gpio_o", {24'b0, gpio_o}, 32'h0);
    chk("rst_gpio_oe", {24'b0, gpio_oe_o}, 32'h0);
    chk("rst_irq", {31'b0, irq_o}, 32'h0);
    chk("rst_unsel_data", data_o, 32'h0);
    rd("rst_rd_out", 3'd0, 32'h0);
    rd("rst_rd_dir", 3'd1, 32'h0);
    rd("rst_rd_ie", 3'd3, 32'h0);
    rd("rst_rd_edge", 3'd4, 32'h0);
    rd("rst_rd_ip", 3'd5, 32'h0);
    gpio_i = 8'h00;
    rst_i  = 1'b0;
    tick(3);

    // Output latch, direction and atomic aliases
    wr(3'd0, 32'h0000_00A5);
    wr(3'd1, 32'h0000_00FF);
    chk("out_a5", {24'b0, gpio_o}, 32'hA5);
    chk("oe_ff", {24'b0, gpio_oe_o}, 32'hFF);
    wr(3'd6, 32'h0000_000F);
    chk("set_0f", {24'b0, gpio_o}, 32'hAF);
    rd("rd_out_af", 3'd0, 32'hAF);
    wr(3'd7, 32'h0000_00A0);
    chk("clr_a0", {24'b0, gpio_o}, 32'h0F);
    rd("rd_set_zero", 3'd6, 32'h0);
    rd("rd_clr_zero", 3'd7, 32'h0);
    wr(3'd0, 32'hFFFF_FF00);
    chk("out_upper_ignored", {24'b0, gpio_o}, 32'h00);
    rd("rd_out_00", 3'd0, 32'h0);
    rd("rd_dir_ff", 3'd1, 32'hFF);
    wr(3'd2, 32'h0000_0055);
    rd("in_write_ignored", 3'd2, 32'h0);

    // Synchroniser latency, pin0 rises with IE=0 (event discarded)
    gpio_i = 8'h01;
    tick(1);
    rd("sync_before_k1", 3'd2, 32'h00);
    tick(1);
    rd("sync_after_k1", 3'd2, 32'h01);
    tick(2);
    rd("masked_rise_ip", 3'd5, 32'h0);
    gpio_i = 8'h00;
    tick(3);

    // Rising-edge interrupt on pin0
    wr(3'd3, 32'h01);
    wr(3'd4, 32'h01);
    gpio_i = 8'h01;
    tick(2);
    rd("rise_in_vis", 3'd2, 32'h01);
    chk("rise_irq_not_yet", {31'b0, irq_o}, 32'h0);
    tick(1);
    chk("rise_irq", {31'b0, irq_o}, 32'h1);
    rd("rise_ip", 3'd5, 32'h01);
    gpio_i = 8'h00;
    tick(3);
    rd("fall_ignored_ip", 3'd5, 32'h01);
    wr(3'd5, 32'h01);
    rd("w1c_ip", 3'd5, 32'h0);
    chk("w1c_irq", {31'b0, irq_o}, 32'h0);

    // Falling-edge interrupt on pin1, then masking
    wr(3'd4, 32'h00);
    wr(3'd3, 32'h02);
    gpio_i = 8'h02;
    tick(3);
    rd("rise_not_fall_ip", 3'd5, 32'h0);
    gpio_i = 8'h00;
    tick(3);
    rd("fall_ip", 3'd5, 32'h02);
    chk("fall_irq", {31'b0, irq_o}, 32'h1);
    wr(3'd3, 32'h00);
    chk("mask_irq", {31'b0, irq_o}, 32'h0);
    rd("mask_ip_kept", 3'd5, 32'h02);
    gpio_i = 8'h04;
    tick(3);
    gpio_i = 8'h00;
    tick(3);
    rd("pin2_disabled_ip", 3'd5, 32'h02);

    // W1C colliding with a new bit0 event: the event wins
    wr(3'd3, 32'h03);
    wr(3'd4, 32'h01);
    chk("unmask_irq", {31'b0, irq_o}, 32'h1);
    gpio_i = 8'h01;
    tick(3);
    rd("pre_collide_ip", 3'd5, 32'h03);
    gpio_i = 8'h00;
    tick(3);
    gpio_i = 8'h01;
    tick(2);
    wr(3'd5, 32'h01);
    rd("collide_ip", 3'd5, 32'h03);
    tick(1);

    // One-cycle reset mid-operation, colliding with a write to OUT
    rst_i  = 1'b1;
    sel_i  = 1'b1;
    wen_i  = 1'b1;
    addr_i = 3'd0;
    data_i = 32'hFF;
    tick(1);
    rst_i  = 1'b0;
    sel_i  = 1'b0;
    wen_i  = 1'b0;
    data_i = '0;
    rd("rst2_ip", 3'd5, 32'h0);
    chk("rst2_irq", {31'b0, irq_o}, 32'h0);
    rd("rst2_in", 3'd2, 32'h0);
    chk("rst2_out_over_write", {24'b0, gpio_o}, 32'h0);
    tick(3);
    rd("post_rst_in", 3'd2, 32'h01);
    rd("post_rst_ip", 3'd5, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gpio_bidir.md
Name: gpio_bidir

Overview:
- Parametrised bidirectional GPIO peripheral on the Matrak M10 peripheral bus; next generation of the 8-bit output-only GPIO.
- Provides a per-pin output latch and direction control, plus atomic set/clear aliases.
- Synchronises pin inputs and detects per-pin rising/falling edges with latched, maskable interrupt pending bits.
- Drives a single level interrupt line to the interrupt controller.

Parameters:
- WIDTH, 8, number of GPIO pins (1..32)
- SYNC_STAGES, 2, input synchroniser flop count (2..3)

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset; one clock; reset is synchronous and active-high
- sel_i  in  1  peripheral select
- wen_i  in  1  write enable (1=write, 0=read)
- addr_i  in  3  register word index
- data_i  in  32  write data from CPU
- data_o  out  32  read data to CPU
- gpio_i  in  WIDTH  asynchronous pin inputs
- gpio_o  out  WIDTH  pin output values
- gpio_oe_o  out  WIDTH  pin output enables (1=drive)
- irq_o  out  1  interrupt request, level, active-high

Behaviour:
- Register map by addr_i:
  - 0 OUT rw
  - 1 DIR rw (1=output)
  - 2 IN ro
  - 3 IE rw
  - 4 EDGE rw (1=rising, 0=falling)
  - 5 IP r/W1C
  - 6 SET wo (OUT |= data)
  - 7 CLR wo (OUT &= ~data)
- Write occurs at the clk_i edge when sel_i & wen_i.
  - Only data_i[WIDTH-1:0] is used; upper bits are ignored.
  - Writes to IN have no effect.
- Read path is combinational.
  - When sel_i & !wen_i: data_o = zero-extended register.
  - SET/CLR read as 0.
  - Otherwise data_o = 32'b0.
- Output assignments:
  - gpio_o = OUT and gpio_oe_o = DIR, both registered direct.
  - OUT is not gated by DIR.
- Input path:
  - gpio_i passes through a SYNC_STAGES flop chain; sync = last stage.
  - One further flop holds prev = previous sync.
  - IN reads sync regardless of DIR.
  - Latency: a change on gpio_i sampled at edge k is visible in IN after edge k+SYNC_STAGES-1.
- Edge event per bit i:
  - EDGE[i] ? (sync[i] & ~prev[i]) : (~sync[i] & prev[i]).
- IP update per bit, each cycle:
  - IP[i] <= (IP[i] & ~w1c[i]) | (event[i] & IE[i]).
  - w1c = data_i when writing addr 5.
  - Set wins over simultaneous clear.
  - Events with IE[i]=0 are discarded, not latched.
- irq_o = |(IP & IE), combinational from registers.
  - Clearing an IE bit masks an already pending bit without clearing it.
- Writing EDGE may create a spurious event only if it coincides with a real transition. No special handling.
- Reset (synchronous): OUT, DIR, IE, EDGE, IP, all sync and prev flops = 0.
  - Hence gpio_o=0, gpio_oe_o=0, irq_o=0, data_o=0 when not selected.
  - Reset mid-operation discards pending interrupts and in-flight synchroniser contents.
  - Reset has priority over any same-cycle write.
  - After reset, a pin held high produces a rising event once synchronised; it is discarded because IE=0.

Decomposition:
- Shared package gpio_pkg: address constants (GPIO_OUT=0, GPIO_DIR=1, GPIO_IN=2, GPIO_IE=3, GPIO_EDGE=4, GPIO_IP=5, GPIO_SET=6, GPIO_CLR=7), GPIO_MAX_WIDTH=32.
- One sub-module gpio_sync: parametrised WIDTH × SYNC_STAGES flop chain, synchronous reset to 0, output sync.
- Edge detect, registers and bus decode stay in gpio_bidir.

Test Plan:
- Reset: hold rst_i 2 cycles with gpio_i=0xFF -> gpio_o=0x00, gpio_oe_o=0x00, irq_o=0; reads of addr 0,1,3,4,5 return 0.
- Output and atomics: write OUT=0xA5, DIR=0xFF -> gpio_o=0xA5, oe=0xFF. SET 0x0F -> OUT=0xAF. CLR 0xA0 -> OUT=0x0F. Read addr 6/7 -> 0. Write 0xFFFFFF00 to OUT -> OUT=0x00.
- Sync latency (SYNC_STAGES=2): gpio_i 0x00->0x01 sampled at edge k -> IN=0x00 before edge k+1, IN=0x01 after edge k+1.
- Rising IRQ: IE=0x01, EDGE=0x01, pin0 0->1 -> IP=0x01, irq_o=1 one cycle after IN changes. Pin0 1->0 -> no change. W1C 0x01 -> IP=0, irq_o=0.
- Falling IRQ and mask:
  - EDGE=0x00, IE=0x02, pin1 1->0 -> IP=0x02.
  - Write IE=0 -> irq_o=0, IP still 0x02.
  - Pin2 falls with IE[2]=0 -> IP[2] stays 0.
- Collisions: W1C IP bit0 in the same cycle a new bit0 event occurs -> IP[0]=1. Assert rst_i one cycle with IP=0x03 -> IP=0, irq_o=0, IN=0.
